// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and state type for the horizontal and vertical stages.
// Default timing is 640x480 at 60 Hz.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam bit H_SYNC_POL = 1'b0;
    localparam bit V_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } vstate_t;

    function automatic int frame_total(input int disp, input int front,
                                       input int sync, input int back);
        return disp + front + sync + back;
    endfunction

endpackage

// File: rtl/vsync_line_gen_if.sv
// Line-rate signals between the horizontal stage, the vertical stage and pixel logic.
interface vsync_line_gen_if #(
    parameter int LINE_W = 10
) ();

    logic              h_tick;
    logic              h_video;
    logic              v_sync;
    logic              v_video;
    logic              video_on;
    logic [LINE_W-1:0] pixel_y;
    logic              frame_tick;

    modport master (
        output h_tick,
        output h_video,
        input  v_sync,
        input  v_video,
        input  video_on,
        input  pixel_y,
        input  frame_tick
    );

    modport slave (
        input  h_tick,
        input  h_video,
        output v_sync,
        output v_video,
        output video_on,
        output pixel_y,
        output frame_tick
    );

endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with enable, synchronous clear and a wrap pulse on N-1 -> 0.
// Out-of-range values fall back to 0 on the next clock.
module mod_n_counter #(
    parameter int N = 800,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        wrap    = 1'b0;
        if (clr || (count_q > LAST)) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == LAST) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;

endmodule

// File: rtl/vsync_line_gen.sv
// Vertical timing stage: counts lines on h_tick, produces v_sync, v_video,
// pixel_y, frame_tick and the combined video_on enable.
//
//   state   | meaning
//   --------+---------------------------------------------
//   VISIBLE | lines 0 .. V_DISPLAY-1, video enabled
//   FRONT   | vertical front porch
//   SYNC    | vertical sync pulse asserted
//   BACK    | vertical back porch, ends at line wrap
module vsync_line_gen
    import vga_timing_pkg::*;
#(
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter bit SYNC_POL  = vga_timing_pkg::V_SYNC_POL,
    parameter int LINE_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    vsync_line_gen_if.slave  vif
);

    localparam int TOTAL = frame_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [LINE_W-1:0] LN_FRONT = LINE_W'(V_DISPLAY);
    localparam logic [LINE_W-1:0] LN_SYNC  = LINE_W'(V_DISPLAY + V_FRONT);
    localparam logic [LINE_W-1:0] LN_BACK  = LINE_W'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [LINE_W-1:0] LN_LAST  = LINE_W'(TOTAL - 1);

    vstate_t           state_q;
    vstate_t           state_d;
    logic              clr;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;
    logic              wrap;
    logic              v_sync_q;
    logic              v_sync_d;
    logic              v_video_q;
    logic              v_video_d;
    logic              frame_tick_q;
    logic              frame_tick_d;

    mod_n_counter #(
        .N (TOTAL),
        .W (LINE_W)
    ) u_line_cnt (
        .clk       (clk),
        .rst_n     (reset),
        .en        (vif.h_tick),
        .clr       (clr),
        .count     (line_q),
        .count_nxt (line_d),
        .wrap      (wrap)
    );

    // Transitions look at the counter's next value so the registered
    // outputs move on the same edge as pixel_y.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            VISIBLE: if (vif.h_tick && (line_d == LN_FRONT)) state_d = FRONT;
            FRONT:   if (vif.h_tick && (line_d == LN_SYNC))  state_d = SYNC;
            SYNC:    if (vif.h_tick && (line_d == LN_BACK))  state_d = BACK;
            BACK:    if (vif.h_tick && wrap)                 state_d = VISIBLE;
            default: begin
                state_d = VISIBLE;
                clr     = 1'b1;
            end
        endcase
        if (line_q > LN_LAST) begin
            state_d = VISIBLE;
        end
    end

    always_comb begin
        v_sync_d     = (state_d == SYNC) ? SYNC_POL : ~SYNC_POL;
        v_video_d    = (state_d == VISIBLE);
        frame_tick_d = wrap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= VISIBLE;
            v_sync_q     <= ~SYNC_POL;
            v_video_q    <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_sync_q     <= v_sync_d;
            v_video_q    <= v_video_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vif.v_sync     = v_sync_q;
    assign vif.v_video    = v_video_q;
    assign vif.pixel_y    = line_q;
    assign vif.frame_tick = frame_tick_q;
    assign vif.video_on   = vif.h_video & v_video_q;

endmodule

// File: tb/tb_vsync_line_gen.sv
// Scoreboard bench for vsync_line_gen: stimulus queues expected line state per h_tick,
// a negedge monitor pops and compares, and checks outputs hold between ticks.
module tb_vsync_line_gen;

    typedef struct {
        int y;
        int vvid;
        int vsync;
        int ftick;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vsync_line_gen_if #(.LINE_W(10)) vif ();

    vsync_line_gen #(
        .V_DISPLAY (480),
        .V_FRONT   (10),
        .V_SYNC    (2),
        .V_BACK    (33),
        .SYNC_POL  (1'b0),
        .LINE_W    (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t cur;
    exp_t e;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   m_y        = 0;
    int   ftick_seen = 0;
    int   max_y      = 0;
    bit   tick_seen  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected line state: visible below 480, sync low on 490 and 491.
    function automatic exp_t model(input int y, input int ft);
        exp_t r;
        r.y     = y;
        r.vvid  = (y < 480) ? 1 : 0;
        r.vsync = (y == 490 || y == 491) ? 0 : 1;
        r.ftick = ft;
        return r;
    endfunction

    always @(posedge clk) begin
        tick_seen = (vif.h_tick === 1'b1) && (reset === 1'b1);
    end

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            cur = model(0, 0);
        end else if (tick_seen) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("tick_pixel_y",    int'(vif.pixel_y),    e.y);
                chk("tick_v_video",    int'(vif.v_video),    e.vvid);
                chk("tick_v_sync",     int'(vif.v_sync),     e.vsync);
                chk("tick_frame_tick", int'(vif.frame_tick), e.ftick);
                cur       = e;
                cur.ftick = 0;
            end
        end else begin
            chk("hold_pixel_y",    int'(vif.pixel_y),    cur.y);
            chk("hold_v_video",    int'(vif.v_video),    cur.vvid);
            chk("hold_v_sync",     int'(vif.v_sync),     cur.vsync);
            chk("hold_frame_tick", int'(vif.frame_tick), 0);
        end
        if (vif.frame_tick === 1'b1) ftick_seen++;
        if (int'(vif.pixel_y) > max_y) max_y = int'(vif.pixel_y);
    end

    task automatic tick(input int gap);
        @(negedge clk);
        vif.h_tick = 1'b1;
        m_y = (m_y + 1) % 525;
        sb.push_back(model(m_y, (m_y == 0) ? 1 : 0));
        @(negedge clk);
        vif.h_tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic held(input int n);
        @(negedge clk);
        vif.h_tick = 1'b1;
        for (int i = 0; i < n; i++) begin
            m_y = (m_y + 1) % 525;
            sb.push_back(model(m_y, (m_y == 0) ? 1 : 0));
            @(negedge clk);
        end
        vif.h_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_to(input int target, input int gap);
        while (m_y != target) tick(gap);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vif.h_tick  = 1'b0;
        vif.h_video = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_pixel_y",    int'(vif.pixel_y),    0);
        chk("reset_v_video",    int'(vif.v_video),    1);
        chk("reset_v_sync",     int'(vif.v_sync),     1);
        chk("reset_frame_tick", int'(vif.frame_tick), 0);
        @(negedge clk);
        reset = 1'b1;

        // Mid-frame reset after 200 lines.
        repeat (200) tick(2);
        @(negedge clk);
        reset = 1'b0;
        m_y   = 0;
        #1;
        chk("midrst_pixel_y",    int'(vif.pixel_y),    0);
        chk("midrst_v_video",    int'(vif.v_video),    1);
        chk("midrst_v_sync",     int'(vif.v_sync),     1);
        chk("midrst_frame_tick", int'(vif.frame_tick), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        tick(3);

        // Finish this frame slowly, then a full frame with tight spacing.
        run_to(0, 15);
        repeat (525) tick(1);

        run_to(100, 1);
        @(negedge clk);
        vif.h_video = 1'b1;
        #1 chk("video_on_y100_hv1", int'(vif.video_on), 1);
        vif.h_video = 1'b0;
        #1 chk("video_on_y100_hv0", int'(vif.video_on), 0);
        vif.h_video = 1'b1;
        #1 chk("video_on_y100_hv1b", int'(vif.video_on), 1);
        vif.h_video = 1'b0;

        run_to(478, 1);
        held(3);
        #1;
        chk("held_pixel_y", int'(vif.pixel_y), 481);
        chk("held_v_video", int'(vif.v_video), 0);

        run_to(485, 1);
        @(negedge clk);
        vif.h_video = 1'b1;
        #1 chk("video_on_y485_hv1", int'(vif.video_on), 0);
        vif.h_video = 1'b0;
        #1 chk("video_on_y485_hv0", int'(vif.video_on), 0);

        repeat (5) @(negedge clk);
        chk("frame_tick_count", ftick_seen, 2);
        chk("max_pixel_y_le_524", (max_y <= 524) ? 1 : 0, 1);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vsync_line_gen.md
Name: vsync_line_gen

Overview:
- Vertical timing stage that consumes the end-of-line pulse from the horizontal sync stage.
- Counts scan lines and produces the VGA vertical sync, the vertical video-enable, the current line number and a frame-start pulse.
- Combines its vertical enable with the incoming horizontal enable to form the final pixel-visible signal for the pixel/render logic.
- Default timing: 640x480 at 60 Hz, 525 lines per frame.

Parameters:
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, front-porch lines
- V_SYNC, 2, sync-pulse lines
- V_BACK, 33, back-porch lines
- SYNC_POL, 0, active level of v_sync (0 = active-low)
- LINE_W, 10, width of line counter; must satisfy 2^LINE_W > total lines

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- h_tick  in  1  one-clk pulse marking the last pixel of each line
- h_video  in  1  horizontal visible-region enable
- v_sync  out  1  vertical sync, level per SYNC_POL
- v_video  out  1  high during visible lines
- video_on  out  1  h_video AND v_video
- pixel_y  out  LINE_W  current line number, 0..TOTAL-1
- frame_tick  out  1  one-clk pulse when line wraps to 0

Behaviour:
- TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK, which is 525 by default.
- Reset is asynchronous, active-low. While reset=0:
  - line counter = 0
  - state = VISIBLE
  - v_sync = ~SYNC_POL (inactive, 1 by default)
  - v_video = 1
  - frame_tick = 0
  - pixel_y = 0
- Deasserting reset mid-frame always restarts at line 0.
- Line counter advances by 1 on every clk edge where h_tick=1. It does nothing else.
  - Counter wraps from TOTAL-1 to 0.
  - h_tick held high for N cycles advances N lines. Upstream guarantees single-cycle pulses; the bench checks the counting rule only.
- State machine: VISIBLE, FRONT, SYNC, BACK. Transitions occur only on h_tick, based on the next counter value:
  - VISIBLE -> FRONT when next line = V_DISPLAY (480)
  - FRONT -> SYNC when next line = V_DISPLAY+V_FRONT (490)
  - SYNC -> BACK when next line = V_DISPLAY+V_FRONT+V_SYNC (492)
  - BACK -> VISIBLE when next line wraps to 0
- Output registration and timing:
  - v_sync, v_video and pixel_y are registered and decoded from next state/count, so they change on the same clk edge as the counter. Latency from h_tick sample to output change is 1 clk.
  - v_sync = SYNC_POL in state SYNC, otherwise ~SYNC_POL. By default v_sync is low on lines 490 and 491.
  - v_video = 1 only in VISIBLE (lines 0..479).
  - frame_tick = 1 for exactly one clk, registered on the edge where the counter wraps 524 -> 0. It is 0 otherwise, including after reset release.
  - video_on is combinational: h_video & v_video, with no added latency.
- Illegal state encoding recovers to VISIBLE with counter 0 on the next clk.
- No behaviour depends on the 25 MHz enable directly; h_tick already carries pixel-rate qualification.

Decomposition:
- Shared package vga_timing_pkg holds:
  - horizontal and vertical timing constants (display, front, sync, back, total)
  - sync polarities
  - vstate_t enum {VISIBLE, FRONT, SYNC, BACK}
  - the horizontal stage uses the same package
- One natural sub-module: mod_n_counter (enable, wrap pulse, parameter N, width W), instantiated with N=TOTAL and enable=h_tick. The same counter is reusable for the horizontal stage.

Test Plan:
- Reset mid-frame: drive 200 h_ticks, assert reset low for 3 clks -> immediately pixel_y=0, v_video=1, v_sync=1, frame_tick=0; after release, first h_tick gives pixel_y=1.
- Full frame: 525 single-cycle h_ticks spaced 800 clks apart ->
  - v_video falls when pixel_y becomes 480
  - v_sync low exactly while pixel_y is 490 and 491
  - v_video rises when pixel_y returns to 0
  - frame_tick high for exactly one clk at that wrap
- Latency: h_tick on edge k -> pixel_y changes on edge k, visible in the cycle after; no change in cycles without h_tick.
- Two consecutive frames: frame_tick pulses every 525 h_ticks, 2 pulses total; pixel_y never exceeds 524.
- video_on gating:
  - pixel_y=100 with h_video toggled -> video_on follows h_video the same cycle
  - pixel_y=485 -> video_on=0 regardless of h_video
- Held h_tick: h_tick high for 3 consecutive clks starting at line 478 -> pixel_y=481 and v_video=0, with no glitch on v_sync.
